// File: rtl/reg_loader_pkg.sv
// Shared types for the vector register loader.
// FSM state encoding used by reg_loader.
package reg_loader_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      WRITE = 1'b1
   } state_e;

endpackage

// File: rtl/reg_loader.sv
// Packs a stream of N-bit words into WIDTH_VECTOR-lane vectors and writes them out.
// Define REG_LOADER_WRAP_EN to let the write pointer wrap instead of stalling when full.
module reg_loader
   import reg_loader_pkg::*;
#(
   parameter int WIDTH_ADDR   = 4,
   parameter int WIDTH_VECTOR = 8,
   parameter int N            = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clear,
   input  logic                              s_valid,
   input  logic [N-1:0]                      s_data,
   output logic                              s_ready,
   output logic                              we,
   output logic [WIDTH_ADDR-1:0]             addr,
   output logic [WIDTH_VECTOR-1:0][N-1:0]    wdata,
   output logic [WIDTH_ADDR:0]               count,
   output logic                              full
);

   localparam int LW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
   localparam logic [WIDTH_ADDR:0] DEPTH = {1'b1, {WIDTH_ADDR{1'b0}}};
   localparam logic [LW-1:0] LAST_LANE = LW'(WIDTH_VECTOR - 1);

   state_e                           state_q, state_d;
   logic [LW-1:0]                    lane_idx_q, lane_idx_d;
   logic [WIDTH_ADDR-1:0]            wr_ptr_q, wr_ptr_d;
   logic [WIDTH_ADDR:0]              count_q, count_d;
   logic [WIDTH_VECTOR-1:0][N-1:0]   wdata_q, wdata_d;
   logic                             xfer;

`ifdef REG_LOADER_WRAP_EN
   assign full    = 1'b0;
   assign s_ready = rst_n && (state_q == FILL);
`else
   assign full    = (count_q == DEPTH);
   assign s_ready = rst_n && (state_q == FILL) && !full;
`endif

   assign xfer  = s_valid && s_ready;
   assign we    = (state_q == WRITE);
   assign addr  = wr_ptr_q;
   assign wdata = wdata_q;
   assign count = count_q;

   always_comb begin
      state_d    = state_q;
      lane_idx_d = lane_idx_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      wdata_d    = wdata_q;
      unique case (state_q)
         FILL: begin
            // clear wins over a same-cycle transfer; the partial vector is dropped
            if (clear) begin
               lane_idx_d = '0;
               wr_ptr_d   = '0;
               count_d    = '0;
            end else if (xfer) begin
               wdata_d[lane_idx_q] = s_data;
               if (lane_idx_q == LAST_LANE) begin
                  lane_idx_d = '0;
                  state_d    = WRITE;
               end else begin
                  lane_idx_d = lane_idx_q + 1'b1;
               end
            end
         end
         WRITE: begin
            state_d = FILL;
            if (clear) begin
               lane_idx_d = '0;
               wr_ptr_d   = '0;
               count_d    = '0;
            end else begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (count_q != DEPTH) count_d = count_q + 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FILL;
         lane_idx_q <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         lane_idx_q <= lane_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_reg_loader.sv
// Directed self-checking bench for reg_loader (default parameters).
// Expectations follow REG_LOADER_WRAP_EN when the bench is built with it.
module tb_reg_loader;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                clear;
   logic                s_valid;
   logic [31:0]         s_data;
   logic                s_ready;
   logic                we;
   logic [3:0]          addr;
   logic [7:0][31:0]    wdata;
   logic [4:0]          count;
   logic                full;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ptr  = 0;
   int exp_cnt  = 0;

`ifdef REG_LOADER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   reg_loader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .count   (count),
      .full    (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] vec(input logic [31:0] base);
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
      return v;
   endfunction

   task automatic push_vec(input logic [31:0] base, input int gap_after,
                           input int gap_len, input bit clr_wr,
                           input bit rst_wr);
      for (int k = 0; k < 8; k++) begin
         if (k == gap_after) begin
            s_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               check("gap_we", we, 0);
               tick();
            end
         end
         s_valid = 1'b1;
         s_data  = base + 32'(k);
         check("fill_rdy", s_ready, 1);
         check("fill_we", we, 0);
         tick();
      end
      s_valid = 1'b0;
      check("wr_we", we, 1);
      check("wr_rdy", s_ready, 0);
      check("wr_addr", addr, exp_ptr);
      check("wr_data", wdata, vec(base));
      if (clr_wr) clear = 1'b1;
      if (rst_wr) rst_n = 1'b0;
      tick();
      clear = 1'b0;
      if (clr_wr || rst_wr) begin
         exp_ptr = 0;
         exp_cnt = 0;
      end else begin
         exp_ptr = (exp_ptr + 1) % 16;
         if (exp_cnt < 16) exp_cnt++;
      end
      check("post_we", we, 0);
      check("post_cnt", count, exp_cnt);
      check("post_full", full, (!WRAP && exp_cnt == 16));
      if (rst_wr) begin
         check("rst_rdy", s_ready, 0);
         check("rst_data", wdata, 0);
         check("rst_addr", addr, 0);
         rst_n = 1'b1;
         #1;
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      tick();
      tick();
      check("rst_rdy_low", s_ready, 0);
      check("rst_we", we, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      rst_n = 1'b1;
      #1;
      check("rdy_after_rst", s_ready, 1);

      // back-to-back vector, then one with a 3-cycle bubble
      push_vec(32'h0, -1, 0, 1'b0, 1'b0);
      push_vec(32'h0, 4, 3, 1'b0, 1'b0);

      for (int i = 2; i < 16; i++)
         push_vec(32'(i * 16), -1, 0, 1'b0, 1'b0);
      check("cnt16", count, 16);
      check("full16", full, !WRAP);
      check("rdy16", s_ready, WRAP);
      if (WRAP) begin
         push_vec(32'h100, -1, 0, 1'b0, 1'b0);
         check("wrap_cnt", count, 16);
      end else begin
         s_valid = 1'b1;
         for (int c = 0; c < 10; c++) begin
            s_data = 32'h100 + 32'(c);
            check("blk_rdy", s_ready, 0);
            check("blk_we", we, 0);
            tick();
         end
         s_valid = 1'b0;
         check("blk_cnt", count, 16);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_ptr = 0;
      exp_cnt = 0;
      check("clr_rdy", s_ready, 1);
      check("clr_addr", addr, 0);
      check("clr_cnt", count, 0);
      check("clr_full", full, 0);

      // clear mid-vector discards the partial lanes
      s_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_data = 32'h10 + 32'(k);
         tick();
      end
      s_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("midclr_we", we, 0);
      check("midclr_cnt", count, 0);
      push_vec(32'hA0, -1, 0, 1'b0, 1'b0);

      // clear during the write to address 3
      push_vec(32'h20, -1, 0, 1'b0, 1'b0);
      push_vec(32'h30, -1, 0, 1'b0, 1'b0);
      push_vec(32'h40, -1, 0, 1'b1, 1'b0);
      check("wrclr_addr", addr, 0);
      push_vec(32'h50, -1, 0, 1'b0, 1'b0);
      check("wrclr_cnt", count, 1);

      // reset during write kills we on the next cycle
      push_vec(32'h60, -1, 0, 1'b0, 1'b1);
      check("postrst_rdy", s_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_loader.md
REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 4: vector address width; depth = 2**WIDTH_ADDR.
REQ-002 SHALL have parameter WIDTH_VECTOR, default 8: words (lanes) per vector.
REQ-003 SHALL have parameter N, default 32: bits per word.
REQ-004 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port clear  input  1: synchronous restart of pointer, count and partial vector.
REQ-007 SHALL have port s_valid  input  1: input word valid.
REQ-008 SHALL have port s_data  input  N: input word.
REQ-009 SHALL have port s_ready  output  1: loader accepts s_data this cycle.
REQ-010 SHALL have port we  output  1: write strobe to the downstream vector register file.
REQ-011 SHALL have port addr  output  WIDTH_ADDR: write address.
REQ-012 SHALL have port wdata  output  [WIDTH_VECTOR-1:0][N-1:0]: assembled vector, lane 0 = first word.
REQ-013 SHALL have port count  output  WIDTH_ADDR+1: vectors written since reset/clear.
REQ-014 SHALL have port full  output  1: count == 2**WIDTH_ADDR.

Function
REQ-015 SHALL implement states FILL and WRITE; word transfer occurs when s_valid && s_ready.
REQ-016 In FILL, s_ready SHALL be 1 unless full; each transfer stores s_data in lane lane_idx, then lane_idx increments.
REQ-017 On the transfer with lane_idx == WIDTH_VECTOR-1, SHALL move to WRITE and clear lane_idx to 0.
REQ-018 In WRITE (exactly one cycle), we SHALL be 1, s_ready 0, addr = wr_ptr, wdata stable; we SHALL be 0 in every other cycle.
REQ-019 we SHALL rise the cycle immediately after the last-lane transfer (latency 1); next state after WRITE is FILL.
REQ-020 At the end of WRITE, wr_ptr SHALL increment modulo 2**WIDTH_ADDR and count SHALL increment saturating at 2**WIDTH_ADDR.
REQ-021 s_valid low mid-vector SHALL hold lane_idx and stored lanes indefinitely.
REQ-022 clear in FILL SHALL, at the next edge, zero lane_idx, wr_ptr, count and discard the partial vector.
REQ-023 clear in WRITE SHALL let that cycle's write complete, then zero lane_idx, wr_ptr, count; state returns to FILL.
REQ-024 wdata lanes SHALL be written only on transfers; unwritten lanes keep prior content.

Reset
REQ-025 With rst_n low at an edge: state FILL, lane_idx 0, wr_ptr 0, count 0, we 0, addr 0, wdata all zero, full 0; s_ready 0 while rst_n is low.
REQ-026 rst_n SHALL take priority over clear; reset during WRITE SHALL suppress we from the next cycle.

Configuration
REQ-027 Macro REG_LOADER_WRAP_EN: when undefined, full blocks further transfers (s_ready 0) until clear or reset.
REQ-028 When REG_LOADER_WRAP_EN is defined, full SHALL be tied 0, s_ready ignores count, wr_ptr wraps and overwrites from address 0, count saturates.

Structure
REQ-029 Shared package reg_loader_pkg SHALL hold the state enum typedef (FILL, WRITE).
REQ-030 No sub-module; single flat module driving the register file's we/addr/wdata directly.

Verification
REQ-031 Reset, then 8 words 0x0..0x7 back-to-back -> we high on cycle 9 only, addr 0, wdata lane k = k, count 1.
REQ-032 8 words with s_valid low 3 cycles after word 4 -> identical wdata, we delayed 3 cycles, no lane shift.
REQ-033 16 vectors (macro off) -> full=1, count=16, s_ready 0; 17th vector's words not accepted; clear -> s_ready 1, addr 0.
REQ-034 Same with REG_LOADER_WRAP_EN -> 17th vector written at addr 0, full 0, count 16.
REQ-035 clear asserted after 5 words, then 8 new words 0xA0..0xA7 -> single write at addr 0 with lanes 0xA0..0xA7.
REQ-036 clear during WRITE of vector at addr 3 -> we high that cycle with addr 3; next vector writes addr 0, count 1.
